// File: rtl/ps2_zx_matrix.sv
// ps2_zx_matrix: turns PS/2 set-2 scan codes into an 8x5 ZX Spectrum key matrix and answers ULA half-row reads.
// Define ZX_CURSOR_KEYS_EN to add backspace/cursor combo keys, each of which also asserts CAPS.
module ps2_zx_matrix #(
  parameter int unsigned RELEASE_ON_ERROR = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_code_ready,
  input  logic       scan_code_error,
  input  logic [7:0] A,
  output logic [4:0] key_row,
  output logic       pressed
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } key_t;

  state_t          state_q, state_d;
  logic [7:0][4:0] keymap_q, keymap_d;
  logic            lshift_q, lshift_d;
  logic            rshift_q, rshift_d;
  logic            pressed_q, pressed_d;
  logic [4:0]      combo_v;
  logic            ext_s;
  key_t            dec_s;
  logic            apply_en_s;
  logic            apply_val_s;
  logic [7:0][4:0] eff_s;
  logic [4:0]      or_s;

  function automatic key_t k(input logic [2:0] r, input logic [2:0] c);
    k = '{hit: 1'b1, row: r, col: c};
  endfunction

  // CAPS (12/59) is tracked per shift key and handled outside this table.
  function automatic key_t map_std(input logic [7:0] code);
    case (code)
      8'h1A: map_std = k(3'd0, 3'd1);
      8'h22: map_std = k(3'd0, 3'd2);
      8'h21: map_std = k(3'd0, 3'd3);
      8'h2A: map_std = k(3'd0, 3'd4);
      8'h1C: map_std = k(3'd1, 3'd0);
      8'h1B: map_std = k(3'd1, 3'd1);
      8'h23: map_std = k(3'd1, 3'd2);
      8'h2B: map_std = k(3'd1, 3'd3);
      8'h34: map_std = k(3'd1, 3'd4);
      8'h15: map_std = k(3'd2, 3'd0);
      8'h1D: map_std = k(3'd2, 3'd1);
      8'h24: map_std = k(3'd2, 3'd2);
      8'h2D: map_std = k(3'd2, 3'd3);
      8'h2C: map_std = k(3'd2, 3'd4);
      8'h16: map_std = k(3'd3, 3'd0);
      8'h1E: map_std = k(3'd3, 3'd1);
      8'h26: map_std = k(3'd3, 3'd2);
      8'h25: map_std = k(3'd3, 3'd3);
      8'h2E: map_std = k(3'd3, 3'd4);
      8'h45: map_std = k(3'd4, 3'd0);
      8'h46: map_std = k(3'd4, 3'd1);
      8'h3E: map_std = k(3'd4, 3'd2);
      8'h3D: map_std = k(3'd4, 3'd3);
      8'h36: map_std = k(3'd4, 3'd4);
      8'h4D: map_std = k(3'd5, 3'd0);
      8'h44: map_std = k(3'd5, 3'd1);
      8'h43: map_std = k(3'd5, 3'd2);
      8'h3C: map_std = k(3'd5, 3'd3);
      8'h35: map_std = k(3'd5, 3'd4);
      8'h5A: map_std = k(3'd6, 3'd0);
      8'h4B: map_std = k(3'd6, 3'd1);
      8'h42: map_std = k(3'd6, 3'd2);
      8'h3B: map_std = k(3'd6, 3'd3);
      8'h33: map_std = k(3'd6, 3'd4);
      8'h29: map_std = k(3'd7, 3'd0);
      8'h14: map_std = k(3'd7, 3'd1);
      8'h3A: map_std = k(3'd7, 3'd2);
      8'h31: map_std = k(3'd7, 3'd3);
      8'h32: map_std = k(3'd7, 3'd4);
      default: map_std = '0;
    endcase
  endfunction

  function automatic key_t map_ext(input logic [7:0] code);
    case (code)
      8'h14:   map_ext = k(3'd7, 3'd1);
      default: map_ext = '0;
    endcase
  endfunction

`ifdef ZX_CURSOR_KEYS_EN
  logic [4:0] combo_q, combo_d;

  // One-hot combo select: bs, left, down, up, right.
  function automatic logic [4:0] map_combo(input logic ext, input logic [7:0] code);
    case ({ext, code})
      9'h066:  map_combo = 5'b00001;
      9'h16B:  map_combo = 5'b00010;
      9'h172:  map_combo = 5'b00100;
      9'h175:  map_combo = 5'b01000;
      9'h174:  map_combo = 5'b10000;
      default: map_combo = 5'b00000;
    endcase
  endfunction

  assign combo_v = combo_q;
`else
  assign combo_v = 5'b00000;
`endif

  assign ext_s = (state_q == EXT) || (state_q == EXT_BRK);
  assign dec_s = ext_s ? map_ext(scan_code) : map_std(scan_code);

  // Prefix FSM and matrix next-state; an error strobe overrides a coincident byte.
  always_comb begin
    state_d     = state_q;
    keymap_d    = keymap_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
`ifdef ZX_CURSOR_KEYS_EN
    combo_d     = combo_q;
`endif
    apply_en_s  = 1'b0;
    apply_val_s = 1'b0;
    pressed_d   = (|keymap_q) | lshift_q | rshift_q | (|combo_v);
    if (scan_code_error) begin
      state_d = IDLE;
      if (RELEASE_ON_ERROR != 0) begin
        keymap_d = '0;
        lshift_d = 1'b0;
        rshift_d = 1'b0;
`ifdef ZX_CURSOR_KEYS_EN
        combo_d  = 5'b00000;
`endif
      end else begin
        keymap_d = keymap_q;
      end
    end else if (scan_code_ready) begin
      case (state_q)
        IDLE: begin
          if (scan_code == 8'hF0) begin
            state_d = BRK;
          end else if (scan_code == 8'hE0) begin
            state_d = EXT;
          end else begin
            apply_en_s  = 1'b1;
            apply_val_s = 1'b1;
          end
        end
        BRK: begin
          state_d    = IDLE;
          apply_en_s = 1'b1;
        end
        EXT: begin
          if (scan_code == 8'hF0) begin
            state_d = EXT_BRK;
          end else begin
            state_d     = IDLE;
            apply_en_s  = 1'b1;
            apply_val_s = 1'b1;
          end
        end
        EXT_BRK: begin
          state_d    = IDLE;
          apply_en_s = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end

    if (apply_en_s) begin
      if (dec_s.hit) begin
        keymap_d[dec_s.row][dec_s.col] = apply_val_s;
      end else if (!ext_s && scan_code == 8'h12) begin
        lshift_d = apply_val_s;
      end else if (!ext_s && scan_code == 8'h59) begin
        rshift_d = apply_val_s;
      end else begin
`ifdef ZX_CURSOR_KEYS_EN
        if (apply_val_s) begin
          combo_d = combo_q | map_combo(ext_s, scan_code);
        end else begin
          combo_d = combo_q & ~map_combo(ext_s, scan_code);
        end
`endif
      end
    end else begin
      keymap_d = keymap_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      keymap_q  <= '0;
      lshift_q  <= 1'b0;
      rshift_q  <= 1'b0;
      pressed_q <= 1'b0;
`ifdef ZX_CURSOR_KEYS_EN
      combo_q   <= 5'b00000;
`endif
    end else begin
      state_q   <= state_d;
      keymap_q  <= keymap_d;
      lshift_q  <= lshift_d;
      rshift_q  <= rshift_d;
      pressed_q <= pressed_d;
`ifdef ZX_CURSOR_KEYS_EN
      combo_q   <= combo_d;
`endif
    end
  end

  // ULA read path: combo keys fold into CAPS and their digit, then selected rows are ORed.
  always_comb begin
    eff_s       = keymap_q;
    eff_s[0][0] = lshift_q | rshift_q | (|combo_v);
    eff_s[4][0] = keymap_q[4][0] | combo_v[0];
    eff_s[3][4] = keymap_q[3][4] | combo_v[1];
    eff_s[4][4] = keymap_q[4][4] | combo_v[2];
    eff_s[4][3] = keymap_q[4][3] | combo_v[3];
    eff_s[4][2] = keymap_q[4][2] | combo_v[4];
    or_s        = 5'b00000;
    for (int r = 0; r < 8; r++) begin
      if (!A[r]) begin
        or_s = or_s | eff_s[r];
      end else begin
        or_s = or_s;
      end
    end
  end

  assign key_row = ~or_s;
  assign pressed = pressed_q;

endmodule
